cond_flag_unit: RTL and testbench

- Execute-stage consumer of the ALU status outputs (Negative, Zero, Carry, Overflow) in the 32-bit ARM-like CPU.
- Holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against the stored flags.
- Gates the register-write, memory-write and PC-source controls and updates the flags only when the instruction executes.
- All control outputs are registered: one-cycle latency into the write-back/fetch control.

---
 rtl/cond_flag_unit_if.sv | 41 ++++
 rtl/cond_flag_unit.sv | 87 ++++++++
 tb/tb_cond_flag_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cond_flag_unit_if.sv
// rtl/cond_flag_unit_if.sv - execute-stage condition/flag control bundle between pipeline and cond_flag_unit
// SquashCnt exists only when COND_SQUASH_CNT_EN is defined.
interface cond_flag_unit_if #(
  parameter int CNT_W = 16
);
  logic       Valid;
  logic       Stall;
  logic       Flush;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic [3:0] Flags;
  logic       CondEx;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       OutValid;
`ifdef COND_SQUASH_CNT_EN
  logic [CNT_W-1:0] SquashCnt;
`endif

  modport master (
`ifdef COND_SQUASH_CNT_EN
    input  SquashCnt,
`endif
    output Valid, Stall, Flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  Flags, CondEx, PCSrc, RegWrite, MemWrite, OutValid
  );

  modport slave (
`ifdef COND_SQUASH_CNT_EN
    output SquashCnt,
`endif
    input  Valid, Stall, Flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output Flags, CondEx, PCSrc, RegWrite, MemWrite, OutValid
  );
endinterface

// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - NZCV flag register, condition evaluation and write-enable gating
// Optional squashed-instruction counter enabled by COND_SQUASH_CNT_EN.
module cond_flag_unit #(
  parameter logic [3:0] FLAG_RST = 4'b0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  cond_flag_unit_if.slave  bus
);

  logic [3:0] flags_q;
  logic       n, z, c, v;
  logic       cond_ex;
  logic       exec;
  logic       pcsrc_q, regwrite_q, memwrite_q, outvalid_q;

  assign {n, z, c, v} = flags_q;

  // Evaluated against the stored flags only; the current ALUFlags are never forwarded.
  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign exec = bus.Valid & cond_ex & ~bus.Flush & ~bus.Stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q    <= FLAG_RST;
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      outvalid_q <= 1'b0;
    end else if (!bus.Stall) begin
      if (exec && bus.FlagW[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
      if (exec && bus.FlagW[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
      pcsrc_q    <= bus.PCS & exec;
      regwrite_q <= bus.RegW & ~bus.NoWrite & exec;
      memwrite_q <= bus.MemW & exec;
      outvalid_q <= bus.Valid & ~bus.Flush;
    end
  end

  assign bus.Flags    = flags_q;
  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = pcsrc_q;
  assign bus.RegWrite = regwrite_q;
  assign bus.MemWrite = memwrite_q;
  assign bus.OutValid = outvalid_q;

`ifdef COND_SQUASH_CNT_EN
  logic [CNT_W-1:0] squash_cnt_q;
  logic             squash;

  assign squash = bus.Valid & ~cond_ex & ~bus.Flush & ~bus.Stall;

  // Saturating: a stuck-at-max counter is more useful to software than a wrapped one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      squash_cnt_q <= '0;
    end else if (squash && (squash_cnt_q != {CNT_W{1'b1}})) begin
      squash_cnt_q <= squash_cnt_q + 1'b1;
    end
  end

  assign bus.SquashCnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb/tb_cond_flag_unit.sv - scoreboard bench for cond_flag_unit with randomized instruction stream
// Covers the COND_SQUASH_CNT_EN build as well when that macro is defined.
module tb_cond_flag_unit;
  localparam int         CW  = 4;
  localparam logic [3:0] FR  = 4'b0000;
  localparam int         MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cond_flag_unit_if #(.CNT_W(CW)) bus ();
  cond_flag_unit #(.FLAG_RST(FR), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [3:0] flags;
    logic       pcsrc, regwrite, memwrite, outvalid;
    int         cnt;
  } exp_t;

  exp_t oq[$];
  bit   cq[$];
  int   checks = 0;
  int   failures = 0;

  logic [3:0] m_flags;
  bit         m_pc, m_rw, m_mw, m_ov;
  int         m_cnt;

  function automatic bit cond_holds(logic [3:0] f, logic [3:0] cond);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      0: return z;          1: return !z;
      2: return c;          3: return !c;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return c && !z;    9: return !c || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (cq.size() > 0) begin
      bit e;
      e = cq.pop_front();
      chk("condex", {31'd0, bus.CondEx}, {31'd0, e});
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (oq.size() > 0) begin
      exp_t e;
      e = oq.pop_front();
      chk("flags", {28'd0, bus.Flags}, {28'd0, e.flags});
      chk("pcsrc", {31'd0, bus.PCSrc}, {31'd0, e.pcsrc});
      chk("regwrite", {31'd0, bus.RegWrite}, {31'd0, e.regwrite});
      chk("memwrite", {31'd0, bus.MemWrite}, {31'd0, e.memwrite});
      chk("outvalid", {31'd0, bus.OutValid}, {31'd0, e.outvalid});
`ifdef COND_SQUASH_CNT_EN
      chk("squashcnt", {{(32-CW){1'b0}}, bus.SquashCnt}, e.cnt);
`endif
    end
  end

  task automatic drive(bit valid, bit stall, bit flush, logic [3:0] cond, logic [3:0] alu,
                       logic [1:0] fw, bit pcs, bit regw, bit memw, bit nw);
    bus.Valid = valid; bus.Stall = stall; bus.Flush = flush; bus.Cond = cond;
    bus.ALUFlags = alu; bus.FlagW = fw; bus.PCS = pcs; bus.RegW = regw;
    bus.MemW = memw; bus.NoWrite = nw;
  endtask

  task automatic model_reset();
    m_flags = FR; m_pc = 0; m_rw = 0; m_mw = 0; m_ov = 0; m_cnt = 0;
  endtask

  task automatic issue(bit valid, bit stall, bit flush, logic [3:0] cond, logic [3:0] alu,
                       logic [1:0] fw, bit pcs, bit regw, bit memw, bit nw);
    bit   ce, ex;
    exp_t e;
    @(posedge clk);
    #2;
    drive(valid, stall, flush, cond, alu, fw, pcs, regw, memw, nw);
    ce = cond_holds(m_flags, cond);
    cq.push_back(ce);
    if (!stall) begin
      ex = valid && ce && !flush;
      if (ex && fw[1]) m_flags[3:2] = alu[3:2];
      if (ex && fw[0]) m_flags[1:0] = alu[1:0];
      m_pc = pcs && ex;
      m_rw = regw && !nw && ex;
      m_mw = memw && ex;
      m_ov = valid && !flush;
      if (valid && !ce && !flush && m_cnt < MAXC) m_cnt++;
    end
    e.flags = m_flags; e.pcsrc = m_pc; e.regwrite = m_rw;
    e.memwrite = m_mw; e.outvalid = m_ov; e.cnt = m_cnt;
    oq.push_back(e);
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_flags"}, {28'd0, bus.Flags}, {28'd0, FR});
    chk({tag, "_pcsrc"}, {31'd0, bus.PCSrc}, 32'd0);
    chk({tag, "_regwrite"}, {31'd0, bus.RegWrite}, 32'd0);
    chk({tag, "_memwrite"}, {31'd0, bus.MemWrite}, 32'd0);
    chk({tag, "_outvalid"}, {31'd0, bus.OutValid}, 32'd0);
`ifdef COND_SQUASH_CNT_EN
    chk({tag, "_squashcnt"}, {{(32-CW){1'b0}}, bus.SquashCnt}, 32'd0);
`endif
  endtask

  // Reset lands between edges with an instruction pending; that instruction must vanish.
  task automatic async_reset();
    @(posedge clk);
    #3;
    drive(1, 0, 0, 4'hE, 4'h0, 2'b11, 1, 1, 1, 0);
    reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    bus.Cond = 4'hF;
    #1;
    chk("nv_condex", {31'd0, bus.CondEx}, 32'd0);
    model_reset();
    drive(0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
    model_reset();
    #1;
    check_reset_state("init_rst");
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    issue(1, 0, 0, 4'hE, 4'b1000, 2'b11, 0, 1, 0, 0);
    issue(1, 0, 0, 4'hB, 4'b0000, 2'b00, 0, 1, 0, 0);
    issue(1, 0, 0, 4'hA, 4'b0101, 2'b11, 0, 1, 0, 0);
    issue(1, 0, 0, 4'hE, 4'b0110, 2'b11, 0, 0, 0, 0);
    issue(1, 0, 0, 4'hE, 4'b1001, 2'b10, 0, 0, 0, 0);
    issue(1, 0, 0, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 1);
    issue(1, 0, 0, 4'h0, 4'b0000, 2'b00, 0, 0, 1, 0);
    issue(1, 0, 0, 4'hE, 4'b0011, 2'b11, 1, 1, 1, 0);
    repeat (3) issue(1, 1, 0, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
    issue(1, 0, 1, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
    issue(1, 1, 1, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
    issue(1, 0, 0, 4'hF, 4'b1111, 2'b11, 1, 1, 1, 0);
    issue(0, 0, 0, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
    issue(1, 0, 0, 4'hE, 4'b1111, 2'b11, 0, 1, 0, 0);
    async_reset();

    for (int i = 0; i < 3000; i++) begin
      issue(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 1),
            4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 3) == 0));
      if (i == 1500) async_reset();
    end

    repeat (2) @(posedge clk);
    #3;
    chk("cq_drained", cq.size(), 32'd0);
    chk("oq_drained", oq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
